macc_seq: RTL
=============

# macc_seq

Loop sequencer for the matrix multiply-accumulate datapath. On a start pulse it walks an R×C output tile with an inner K-length dot-product loop, issuing paired A/B operand reads to operand memory. It delays the read issue by the fixed memory latency so that accumulate clear, enable and last-element strobes reach the MACC array aligned with the returning data. It sits between the host control registers and the operand memories / accumulator.

## Interface
Parameters:
- DIM_W, 10: width of the row, column and K dimension fields.
- ADDR_W, 20: operand address width; must be at least 2*DIM_W.
- RD_LAT, 2: operand memory read latency in cycles; must be at least 1.

Ports:
- CLK  in  1  clock; all state on posedge CLK.
- RST  in  1  reset, asynchronous, active-high.
- VDD, GND  in  1  power pins; no logic function.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current run.
- rows_m1, cols_m1, k_m1  in  DIM_W  tile dimensions minus one; captured on an accepted start.
- rd_ready  in  1  memory can accept a read this cycle.
- rd_en  out  1  read issue strobe.
- a_addr, b_addr  out  ADDR_W  operand addresses.
- acc_en, acc_clr, acc_last  out  1  accumulate strobes, aligned to returned data.
- out_row, out_col  out  DIM_W  coordinate of the finished element; valid when acc_last=1.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE when start=1. Dimensions are captured and all counters and bases are zeroed.
  - ISSUE→DRAIN in the cycle that issues the final element (r=rows_m1, c=cols_m1, k=k_m1).
  - DRAIN→DONE when the delay pipe is empty.
  - DONE→IDLE unconditionally.
- Loop order: k innermost, then c, then r. Indices k, c and r are zero-based.
- Address rules (adders only, no multipliers):
  - a_addr = a_base + k, where a_base advances by (k_m1+1) each time r advances.
  - b_addr = b_base + c, where b_base advances by (cols_m1+1) each time k advances and returns to 0 when k wraps.
  - Equivalently, a_addr = r·K + k and b_addr = k·C + c.
- rd_en = (state==ISSUE) && rd_ready && !abort.
  - Counters advance only on a cycle where rd_en=1.
  - While rd_ready=0, counters and addresses hold.
- Delay pipe: RD_LAT stages carrying {valid, first(k==0), last(k==k_m1), r, c}.
  - The output of the final stage drives acc_en, acc_clr, acc_last, out_row and out_col.
  - acc_clr and acc_last are asserted only together with acc_en.
- abort in ISSUE or DRAIN: next state is IDLE, the pipe is flushed, and done does not pulse.
- start while busy is ignored and is not queued.
- RST: all state, counters, bases and pipe clear immediately to IDLE / 0.

## Timing
- Reset values: every output is 0.
- start accepted in cycle 0: busy=1 and the first possible rd_en occur in cycle 1.
- rd_en and addresses are combinational from registered state and counters.
- acc_en follows the matching rd_en by exactly RD_LAT cycles.
- done is asserted one cycle after the final acc_en. busy=0 in the cycle after done.
- Throughput: one issue per cycle with no stall. Total issues = (rows_m1+1)(cols_m1+1)(k_m1+1).
- Stall bubbles propagate through the pipe as acc_en=0 cycles.

## Structure
- Shared package macc_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - the pipe entry struct {valid, first, last, row, col};
  - default DIM_W, ADDR_W and RD_LAT constants.
- One natural sub-module: macc_loop_cnt. It is a 3-level k/c/r nested counter with an advance enable, producing wrap flags and a final-element flag. The address bases and delay pipe stay in macc_seq.
- Estimated size: about 200–300 lines.

## Test plan
All scenarios use RD_LAT=2.
- 2×2×3 tile (rows_m1=1, cols_m1=1, k_m1=2), rd_ready=1, start in cycle 0:
  - rd_en in cycles 1–12;
  - a_addr = 0,1,2,0,1,2,3,4,5,3,4,5;
  - b_addr = 0,2,4,1,3,5,0,2,4,1,3,5;
  - acc_last in cycles 5, 8, 11, 14 with (row,col) = (0,0), (0,1), (1,0), (1,1);
  - done in cycle 15.
- 1×1×1 tile: rd_en in cycle 1 only; acc_en=acc_clr=acc_last=1 in cycle 3; done in cycle 4; busy=0 in cycle 5.
- 2×2×3 tile with rd_ready=0 in cycles 3–5: address sequence unchanged; issues occupy cycles 1–2 and 6–15; acc_en=0 in cycles 5–7; done in cycle 18.
- abort in cycle 4 of a 2×2×3 run: no rd_en from cycle 4 on; no acc_en after cycle 5; no done; a new start is accepted in the following cycle.
- RST asserted asynchronously mid-ISSUE: all outputs are 0 immediately, without waiting for a clock edge; start pulses arriving while busy are ignored, and the issue count matches a single run.

Source files
------------

// File: rtl/macc_pkg.sv
// macc_pkg: shared types and default parameters for the MACC loop sequencer.
//   state_e   : sequencer states (IDLE/ISSUE/DRAIN/DONE)
//   pipe_t    : one delay-pipe entry {valid, first, last, row, col}
//   *_DEF     : default DIM_W / ADDR_W / RD_LAT values
package macc_pkg;

  localparam int DIM_W_DEF  = 10;
  localparam int ADDR_W_DEF = 20;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Coordinates are sized to the package default width; narrower DIM_W
  // values are zero-extended into it.
  typedef struct packed {
    logic                 valid;
    logic                 first;
    logic                 last;
    logic [DIM_W_DEF-1:0] row;
    logic [DIM_W_DEF-1:0] col;
  } pipe_t;

endpackage

// File: rtl/macc_loop_cnt.sv
// macc_loop_cnt: 3-level nested k/c/r counter (k innermost).
//   clk_i, rst_i        : clock, async active-high reset
//   clr_i               : synchronous clear of all indices (wins over adv_i)
//   adv_i               : advance to the next element
//   k_m1_i/c_m1_i/r_m1_i: loop limits minus one
//   k_o/c_o/r_o         : current indices
//   k_wrap_o            : k is at its limit
//   c_wrap_o            : k and c are at their limits
//   final_o             : current element is the last of the tile
module macc_loop_cnt #(
  parameter int DIM_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [DIM_W-1:0] k_m1_i,
  input  logic [DIM_W-1:0] c_m1_i,
  input  logic [DIM_W-1:0] r_m1_i,
  output logic [DIM_W-1:0] k_o,
  output logic [DIM_W-1:0] c_o,
  output logic [DIM_W-1:0] r_o,
  output logic             k_wrap_o,
  output logic             c_wrap_o,
  output logic             final_o
);

  logic [DIM_W-1:0] k_q, k_d, c_q, c_d, r_q, r_d;

  assign k_wrap_o = (k_q == k_m1_i);
  assign c_wrap_o = k_wrap_o && (c_q == c_m1_i);
  assign final_o  = c_wrap_o && (r_q == r_m1_i);

  always_comb begin
    k_d = k_q;
    c_d = c_q;
    r_d = r_q;
    if (clr_i) begin
      k_d = '0;
      c_d = '0;
      r_d = '0;
    end else if (adv_i) begin
      if (k_wrap_o) begin
        k_d = '0;
        if (c_q == c_m1_i) begin
          c_d = '0;
          r_d = (r_q == r_m1_i) ? '0 : r_q + DIM_W'(1);
        end else begin
          c_d = c_q + DIM_W'(1);
        end
      end else begin
        k_d = k_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= '0;
      c_q <= '0;
      r_q <= '0;
    end else begin
      k_q <= k_d;
      c_q <= c_d;
      r_q <= r_d;
    end
  end

  assign k_o = k_q;
  assign c_o = c_q;
  assign r_o = r_q;

endmodule

// File: rtl/macc_seq.sv
// macc_seq: loop sequencer for the MACC datapath. Walks an R x C tile with
// an inner K loop, issuing paired A/B reads and delaying the accumulate
// strobes by RD_LAT so they line up with the returning operand data.
//   CLK, RST            : clock, async active-high reset
//   VDD, GND            : power pins, no logic function
//   start, abort        : run control
//   rows_m1/cols_m1/k_m1: tile dimensions minus one, captured at start
//   rd_ready            : memory accepts a read this cycle
//   rd_en, a_addr, b_addr          : read issue
//   acc_en, acc_clr, acc_last      : accumulate strobes (data aligned)
//   out_row, out_col    : coordinate of finished element (with acc_last)
//   busy, done          : status
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads, one per ready cycle
// DRAIN | all reads issued, waiting for the delay pipe to empty
// DONE  | one-cycle completion pulse
module macc_seq
  import macc_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VDD,
  input  logic              GND,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  rows_m1,
  input  logic [DIM_W-1:0]  cols_m1,
  input  logic [DIM_W-1:0]  k_m1,
  input  logic              rd_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              acc_last,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              busy,
  output logic              done
);

  if (ADDR_W < 2 * DIM_W) begin : g_chk_addr
    $error("macc_seq: ADDR_W must be at least 2*DIM_W");
  end
  if (RD_LAT < 1) begin : g_chk_lat
    $error("macc_seq: RD_LAT must be at least 1");
  end
  if (DIM_W > DIM_W_DEF) begin : g_chk_dim
    $error("macc_seq: DIM_W exceeds pipe coordinate width");
  end

  localparam int PAD_W = ADDR_W - DIM_W;

  logic unused_pwr;
  assign unused_pwr = VDD ^ GND;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   rows_q, cols_q, kdim_q;
  logic [ADDR_W-1:0]  a_base_q, a_base_d, b_base_q, b_base_d;
  logic [DIM_W-1:0]   k_cnt, c_cnt, r_cnt;
  logic               k_wrap, c_wrap, last_elem;
  pipe_t              pipe_q [RD_LAT];
  pipe_t              pipe_in;
  logic               start_acc, flush, pipe_busy;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign flush     = abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign rd_en     = (state_q == ST_ISSUE) && rd_ready && !abort;

  macc_loop_cnt #(.DIM_W(DIM_W)) u_loop_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (start_acc),
    .adv_i    (rd_en),
    .k_m1_i   (kdim_q),
    .c_m1_i   (cols_q),
    .r_m1_i   (rows_q),
    .k_o      (k_cnt),
    .c_o      (c_cnt),
    .r_o      (r_cnt),
    .k_wrap_o (k_wrap),
    .c_wrap_o (c_wrap),
    .final_o  (last_elem)
  );

  // a_base steps by K per row, b_base steps by C per k; adders only.
  always_comb begin
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    if (start_acc) begin
      a_base_d = '0;
      b_base_d = '0;
    end else if (rd_en) begin
      if (k_wrap) begin
        b_base_d = '0;
      end else begin
        b_base_d = b_base_q + {{PAD_W{1'b0}}, cols_q} + ADDR_W'(1);
      end
      if (last_elem) begin
        a_base_d = '0;
      end else if (c_wrap) begin
        a_base_d = a_base_q + {{PAD_W{1'b0}}, kdim_q} + ADDR_W'(1);
      end
    end
  end

  assign a_addr = a_base_q + {{PAD_W{1'b0}}, k_cnt};
  assign b_addr = b_base_q + {{PAD_W{1'b0}}, c_cnt};

  always_comb begin
    pipe_in = '0;
    if (rd_en) begin
      pipe_in.valid = 1'b1;
      pipe_in.first = (k_cnt == '0);
      pipe_in.last  = k_wrap;
      pipe_in.row   = DIM_W_DEF'(r_cnt);
      pipe_in.col   = DIM_W_DEF'(c_cnt);
    end
  end

  // The final stage is being consumed this cycle, so the pipe is empty
  // after the edge when every earlier stage is invalid.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pipe_busy = pipe_busy | pipe_q[i].valid;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (abort)                  state_d = ST_IDLE;
        else if (rd_en && last_elem) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)           state_d = ST_IDLE;
        else if (!pipe_busy) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      kdim_q   <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      if (start_acc) begin
        rows_q <= rows_m1;
        cols_q <= cols_m1;
        kdim_q <= k_m1;
      end
      if (flush) begin
        for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= pipe_in;
        for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign acc_en   = pipe_q[RD_LAT-1].valid;
  assign acc_clr  = pipe_q[RD_LAT-1].valid && pipe_q[RD_LAT-1].first;
  assign acc_last = pipe_q[RD_LAT-1].valid && pipe_q[RD_LAT-1].last;
  assign out_row  = DIM_W'(pipe_q[RD_LAT-1].row);
  assign out_col  = DIM_W'(pipe_q[RD_LAT-1].col);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule
